// File: rtl/lcd_write_engine.sv
// lcd_write_engine
// Writes a burst of 1..4 bytes to an HD44780-class panel (8-bit, write-only).
// Each byte goes through SETUP -> PULSE -> HOLD -> WAIT. The phases last
// T_SU, T_EW, T_H and the execution delay in cycles. lcd_finish pulses for
// one cycle once the last byte's delay has expired.
// Optional feature macro: LCD_POWERUP_DELAY_EN. When it is defined, a
// T_PWR-cycle power-up hold follows reset, and one start request can be
// held pending during that hold.
module lcd_write_engine #(
   parameter int T_SU        = 2,
   parameter int T_EW        = 12,
   parameter int T_H         = 2,
   parameter int T_REF_WAIT  = 2000,
   parameter int T_INIT_WAIT = 82000,
   parameter int T_PWR       = 750000,
   parameter int CW          = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_enable,
   input  logic       mode,
   input  logic [1:0] lcd_cnt,
   input  logic       reg_sel,
   input  logic [7:0] data_in,
   output logic [1:0] byte_idx,
   output logic       lcd_finish,
   output logic       busy,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_db
);

   // Counter reload values: a phase of N cycles loads N-1 and ends at 0.
   // A parameter of 0 gives the same result as 1.
   localparam logic [CW-1:0] SU_LD   = (T_SU        > 1) ? CW'(T_SU - 1)        : '0;
   localparam logic [CW-1:0] EW_LD   = (T_EW        > 1) ? CW'(T_EW - 1)        : '0;
   localparam logic [CW-1:0] H_LD    = (T_H         > 1) ? CW'(T_H - 1)         : '0;
   localparam logic [CW-1:0] REF_LD  = (T_REF_WAIT  > 1) ? CW'(T_REF_WAIT - 1)  : '0;
   localparam logic [CW-1:0] INIT_LD = (T_INIT_WAIT > 1) ? CW'(T_INIT_WAIT - 1) : '0;
`ifdef LCD_POWERUP_DELAY_EN
   localparam logic [CW-1:0] PWR_LD  = (T_PWR       > 1) ? CW'(T_PWR - 1)       : '0;
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_WAIT,
      ST_DONE
`ifdef LCD_POWERUP_DELAY_EN
      , ST_PWRUP
`endif
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          m_r;
   logic [1:0]    last_r;
   logic          rs_r;
   logic          first_r;
`ifdef LCD_POWERUP_DELAY_EN
   logic          pend_r;
`endif

   // The panel is only ever written, so RW stays low.
   assign lcd_rw = 1'b0;

   // Burst sequencer: state, phase counter, latched request and panel outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
`ifdef LCD_POWERUP_DELAY_EN
         state   <= ST_PWRUP;
         cnt     <= PWR_LD;
         busy    <= 1'b1;
         pend_r  <= 1'b0;
`else
         state   <= ST_IDLE;
         cnt     <= '0;
         busy    <= 1'b0;
`endif
         byte_idx   <= '0;
         lcd_finish <= 1'b0;
         lcd_e      <= 1'b0;
         lcd_rs     <= 1'b0;
         lcd_db     <= '0;
         m_r        <= 1'b0;
         last_r     <= '0;
         rs_r       <= 1'b0;
         first_r    <= 1'b0;
      end else begin
         lcd_finish <= 1'b0;
         unique case (state)
`ifdef LCD_POWERUP_DELAY_EN
            ST_PWRUP: begin
               // A strobe here is remembered. A later strobe overwrites
               // the fields latched by an earlier one.
               if (lcd_enable) begin
                  m_r    <= mode;
                  last_r <= lcd_cnt;
                  rs_r   <= reg_sel;
                  pend_r <= 1'b1;
               end
               if (cnt == '0) begin
                  pend_r <= 1'b0;
                  if (pend_r || lcd_enable) begin
                     byte_idx <= '0;
                     cnt      <= SU_LD;
                     first_r  <= 1'b1;
                     state    <= ST_SETUP;
                  end else begin
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
`endif
            ST_IDLE: begin
               if (lcd_enable) begin
                  m_r      <= mode;
                  last_r   <= lcd_cnt;
                  rs_r     <= reg_sel;
                  byte_idx <= '0;
                  cnt      <= SU_LD;
                  first_r  <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               // By the first SETUP cycle, data_in already reflects the new
               // byte_idx, so RS and DB are captured at the end of that cycle.
               if (first_r) begin
                  lcd_rs  <= rs_r;
                  lcd_db  <= data_in;
                  first_r <= 1'b0;
               end
               if (cnt == '0) begin
                  lcd_e <= 1'b1;
                  cnt   <= EW_LD;
                  state <= ST_PULSE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_PULSE: begin
               if (cnt == '0) begin
                  lcd_e <= 1'b0;
                  cnt   <= H_LD;
                  state <= ST_HOLD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_HOLD: begin
               if (cnt == '0) begin
                  cnt   <= m_r ? INIT_LD : REF_LD;
                  state <= ST_WAIT;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  if (byte_idx == last_r) begin
                     lcd_finish <= 1'b1;
                     state      <= ST_DONE;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                     cnt      <= SU_LD;
                     first_r  <= 1'b1;
                     state    <= ST_SETUP;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE: begin
               byte_idx <= '0;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end
            default: begin
               lcd_e    <= 1'b0;
               byte_idx <= '0;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_write_engine.sv
// tb_lcd_write_engine
// Directed and random bursts for lcd_write_engine, using shortened wait
// parameters. A negedge monitor records each E pulse (start cycle, width,
// DB/RS) and each finish pulse. The bench derives the expected cycle of
// every pulse from the burst timing rules.
module tb_lcd_write_engine;
   localparam int SU = 2;
   localparam int EW = 12;
   localparam int H  = 2;
   localparam int RW = 40;
   localparam int IW = 300;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       lcd_enable = 1'b0;
   logic       mode = 1'b0;
   logic [1:0] lcd_cnt = '0;
   logic       reg_sel = 1'b0;
   logic [7:0] data_in;
   logic [1:0] byte_idx;
   logic       lcd_finish, busy, lcd_e, lcd_rs, lcd_rw;
   logic [7:0] lcd_db;

   logic [7:0] data_mem [4];
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;

   int         rise_q[$];
   int         wid_q[$];
   int         fin_q[$];
   logic [7:0] db_q[$];
   logic       rs_q[$];
   int         hi_len = 0;
   int         unstable = 0;
   int         rw_bad = 0;
   logic       e_prev = 1'b0;

   // Upstream data mux: presents the byte selected by byte_idx.
   assign data_in = data_mem[byte_idx];

   lcd_write_engine #(
      .T_SU(SU), .T_EW(EW), .T_H(H), .T_REF_WAIT(RW), .T_INIT_WAIT(IW),
      .T_PWR(100), .CW(20)
   ) dut (
      .clk(clk), .rst(rst), .lcd_enable(lcd_enable), .mode(mode),
      .lcd_cnt(lcd_cnt), .reg_sel(reg_sel), .data_in(data_in),
      .byte_idx(byte_idx), .lcd_finish(lcd_finish), .busy(busy),
      .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db)
   );

   always #5 clk = ~clk;

   // Count rising edges. The value read at a negedge is the number of the
   // last edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor the panel pins at each negedge.
   always @(negedge clk) begin
      if (lcd_e === 1'b1 && e_prev !== 1'b1) begin
         rise_q.push_back(cyc);
         db_q.push_back(lcd_db);
         rs_q.push_back(lcd_rs);
         hi_len = 1;
      end else if (lcd_e === 1'b1) begin
         hi_len++;
         if (db_q.size() > 0 && (lcd_db !== db_q[$] || lcd_rs !== rs_q[$]))
            unstable++;
      end
      if (lcd_e !== 1'b1 && e_prev === 1'b1) wid_q.push_back(hi_len);
      if (lcd_finish === 1'b1) fin_q.push_back(cyc);
      if (lcd_rw !== 1'b0) rw_bad++;
      e_prev = lcd_e;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Run one burst and check every E pulse and the finish pulse against
   // the timing rules.
   // mid_en: strobe lcd_enable again during the first E pulse.
   // done_en: strobe lcd_enable again on the lcd_finish cycle.
   // b2b: return in the IDLE cycle that follows DONE.
   task automatic do_burst(input logic md, input logic [1:0] n, input logic rs,
                           input logic mid_en, input logic done_en, input logic b2b);
      int s, p, nn, rb, wb, fb, ub;
      bit found, mid_done;
      nn = int'(n);
      rb = rise_q.size();
      wb = wid_q.size();
      fb = fin_q.size();
      ub = unstable;
      p  = SU + EW + H + (md ? IW : RW);
      mode = md; lcd_cnt = n; reg_sel = rs;
      lcd_enable = 1'b1;
      s = cyc + 1;
      tick();
      lcd_enable = 1'b0;
      chk("busy_start", busy, 1);
      found = 0;
      mid_done = 0;
      for (int k = 0; k < 4 * p + 50 && !found; k++) begin
         tick();
         lcd_enable = 1'b0;
         if (mid_en && !mid_done && rise_q.size() > rb) begin
            lcd_enable = 1'b1;
            mid_done = 1;
         end
         if (fin_q.size() > fb) found = 1;
      end
      lcd_enable = 1'b0;
      chk("finish_seen", found, 1);
      if (done_en) begin
         lcd_enable = 1'b1;
         tick();
         lcd_enable = 1'b0;
      end else if (b2b) begin
         tick();
      end
      if (!b2b) repeat (SU + 4) tick();
      chk("n_pulses", rise_q.size() - rb, nn + 1);
      chk("n_widths", wid_q.size() - wb, nn + 1);
      for (int i = 0; i <= nn && rb + i < rise_q.size(); i++) begin
         chk($sformatf("rise%0d", i), rise_q[rb + i], s + i * p + SU);
         chk($sformatf("db%0d", i), db_q[rb + i], data_mem[i]);
         chk($sformatf("rs%0d", i), rs_q[rb + i], rs);
      end
      for (int i = 0; i <= nn && wb + i < wid_q.size(); i++)
         chk($sformatf("width%0d", i), wid_q[wb + i], EW);
      chk("n_finish", fin_q.size() - fb, 1);
      if (fin_q.size() > fb) chk("finish_cyc", fin_q[fb], s + (nn + 1) * p);
      chk("stable_db_rs", unstable - ub, 0);
      chk("busy_idle", busy, 0);
      chk("idx_idle", byte_idx, 0);
   endtask

   initial begin
      int rb, fb, p;
      bit found;
      logic md, rs;
      logic [1:0] n;

      for (int i = 0; i < 4; i++) data_mem[i] = 8'h00;

      // Reset state.
      repeat (3) tick();
      chk("rst_e", lcd_e, 0);
      chk("rst_finish", lcd_finish, 0);
      chk("rst_busy", busy, 0);
      chk("rst_idx", byte_idx, 0);
      chk("rst_rs", lcd_rs, 0);
      chk("rst_rw", lcd_rw, 0);
      chk("rst_db", lcd_db, 8'h00);
      rst = 1'b1;
      repeat (2) tick();

      // Refresh burst of four bytes, RS=1, data 41..44.
      for (int i = 0; i < 4; i++) data_mem[i] = 8'h41 + 8'(i);
      do_burst(1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);

      // Init burst of one byte, RS=0, data 38.
      data_mem[0] = 8'h38;
      do_burst(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Strobes mid-burst and on the DONE cycle are ignored.
      for (int i = 0; i < 4; i++) data_mem[i] = 8'h90 + 8'(i);
      do_burst(1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);

      // Back-to-back: the second burst starts in the IDLE cycle after DONE.
      do_burst(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) data_mem[i] = 8'hA0 + 8'(i);
      do_burst(1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);

      // Reset during the E pulse of byte 2.
      for (int i = 0; i < 4; i++) data_mem[i] = 8'h50 + 8'(i);
      p  = SU + EW + H + RW;
      rb = rise_q.size();
      fb = fin_q.size();
      mode = 1'b0; lcd_cnt = 2'd3; reg_sel = 1'b1;
      lcd_enable = 1'b1;
      tick();
      lcd_enable = 1'b0;
      found = 0;
      for (int k = 0; k < 4 * p && !found; k++) begin
         tick();
         if (rise_q.size() - rb >= 3) found = 1;
      end
      chk("rst_reach_byte2", found, 1);
      tick();
      tick();
      chk("e_high_pre_rst", lcd_e, 1);
      chk("idx_pre_rst", byte_idx, 2);
      #2 rst = 1'b0;
      #1;
      chk("async_e", lcd_e, 0);
      chk("async_busy", busy, 0);
      chk("async_idx", byte_idx, 0);
      chk("async_rs", lcd_rs, 0);
      chk("async_db", lcd_db, 8'h00);
      chk("async_finish", lcd_finish, 0);
      repeat (2) tick();
      rst = 1'b1;
      repeat (3 * p) tick();
      chk("rst_no_finish", fin_q.size() - fb, 0);
      chk("rst_no_more_e", rise_q.size() - rb, 3);
      for (int i = 0; i < 4; i++) data_mem[i] = 8'h61 + 8'(i);
      do_burst(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

      // Random bursts.
      for (int r = 0; r < 8; r++) begin
         md = 1'($urandom_range(0, 1));
         n  = 2'($urandom_range(0, 3));
         rs = 1'($urandom_range(0, 1));
         for (int i = 0; i < 4; i++) data_mem[i] = 8'($urandom);
         repeat ($urandom_range(0, 5)) tick();
         do_burst(md, n, rs, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

      chk("rw_low", rw_bad, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
